// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer for TLBP/TLBR/TLBWI/TLBWR, owns CP0 Random and Wired.
// Optional macro TLB_OP_WRITE_FLUSH_EN adds a one-cycle refetch FLUSH after writes.
module tlb_op_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES),
    parameter int ENTRY_W     = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               op_valid,
    input  logic [1:0]         op_type,
    output logic               op_ready,
    output logic               op_done,
    input  logic [31:0]        cp0_index,
    input  logic [31:0]        cp0_entry_hi,
    input  logic [ENTRY_W-1:0] cp0_entry,
    input  logic               cp0_wired_we,
    input  logic [31:0]        cp0_wired_wdata,
    output logic [IDX_W-1:0]   random,
    output logic [IDX_W-1:0]   tlbrw_index,
    output logic               tlbrw_we,
    output logic [ENTRY_W-1:0] tlbrw_wdata,
    input  logic [ENTRY_W-1:0] tlbrw_rdata,
    output logic [31:0]        tlbp_entry_hi,
    input  logic [31:0]        tlbp_index,
    output logic               index_we,
    output logic [31:0]        index_wdata,
    output logic               entry_we,
    output logic [ENTRY_W-1:0] entry_wdata,
    output logic               tlb_flush
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [1:0] OP_P  = 2'd0;
    localparam logic [1:0] OP_R  = 2'd1;
    localparam logic [1:0] OP_WR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_PRESP,
        S_READ,
        S_RRESP,
        S_WRITE
`ifdef TLB_OP_WRITE_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    state_t state_q, state_d;

    logic [1:0]         type_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        key_q;
    logic [ENTRY_W-1:0] entry_q;
    logic [IDX_W-1:0]   rnd_lat_q;
    logic [IDX_W-1:0]   rand_q, rand_d;
    logic [IDX_W-1:0]   wired_q, wired_d;
    logic               accept;

    logic unused_ok;
    assign unused_ok = ^{cp0_index[31:IDX_W], cp0_wired_wdata[31:IDX_W]};

    assign op_ready = (state_q == S_IDLE);
    assign accept   = op_valid & op_ready;

    // Random steps down towards Wired, wrapping to the top; a Wired write restarts it.
    always_comb begin
        wired_d = wired_q;
        rand_d  = rand_q - 1'b1;
        if (cp0_wired_we) begin
            wired_d = cp0_wired_wdata[IDX_W-1:0];
            rand_d  = LAST;
        end else if (rand_q <= wired_q) begin
            rand_d = LAST;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rand_q  <= LAST;
            wired_q <= '0;
        end else begin
            rand_q  <= rand_d;
            wired_q <= wired_d;
        end
    end

    // Operands are captured with the pre-update Random value for TLBWR.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            type_q    <= '0;
            idx_q     <= '0;
            key_q     <= '0;
            entry_q   <= '0;
            rnd_lat_q <= '0;
        end else if (accept) begin
            type_q    <= op_type;
            idx_q     <= cp0_index[IDX_W-1:0];
            key_q     <= cp0_entry_hi;
            entry_q   <= cp0_entry;
            rnd_lat_q <= rand_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_done  = 1'b0;
        tlbrw_we = 1'b0;
        index_we = 1'b0;
        entry_we = 1'b0;
`ifdef TLB_OP_WRITE_FLUSH_EN
        tlb_flush = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    if (op_type == OP_P) begin
                        state_d = S_PROBE;
                    end else if (op_type == OP_R) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_PROBE: state_d = S_PRESP;
            S_PRESP: begin
                index_we = 1'b1;
                op_done  = 1'b1;
                state_d  = S_IDLE;
            end
            S_READ:  state_d = S_RRESP;
            S_RRESP: begin
                entry_we = 1'b1;
                op_done  = 1'b1;
                state_d  = S_IDLE;
            end
            S_WRITE: begin
                tlbrw_we = 1'b1;
`ifdef TLB_OP_WRITE_FLUSH_EN
                state_d  = S_FLUSH;
`else
                op_done  = 1'b1;
                state_d  = S_IDLE;
`endif
            end
`ifdef TLB_OP_WRITE_FLUSH_EN
            S_FLUSH: begin
                tlb_flush = 1'b1;
                op_done   = 1'b1;
                state_d   = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifndef TLB_OP_WRITE_FLUSH_EN
    assign tlb_flush = 1'b0;
`endif

    assign random        = rand_q;
    assign tlbrw_index   = (type_q == OP_WR) ? rnd_lat_q : idx_q;
    assign tlbrw_wdata   = entry_q;
    assign tlbp_entry_hi = key_q;
    assign index_wdata   = tlbp_index;
    assign entry_wdata   = tlbrw_rdata;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Randomized bench for tlb_op_ctrl against a cycle-phase reference model.
module tb_tlb_op_ctrl;
    localparam int N  = 16;
    localparam int IW = 4;
    localparam int EW = 64;
`ifdef TLB_OP_WRITE_FLUSH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          op_valid;
    logic [1:0]    op_type;
    logic          op_ready, op_done;
    logic [31:0]   cp0_index, cp0_entry_hi;
    logic [EW-1:0] cp0_entry;
    logic          cp0_wired_we;
    logic [31:0]   cp0_wired_wdata;
    logic [IW-1:0] random, tlbrw_index;
    logic          tlbrw_we;
    logic [EW-1:0] tlbrw_wdata, tlbrw_rdata;
    logic [31:0]   tlbp_entry_hi, tlbp_index;
    logic          index_we, entry_we, tlb_flush;
    logic [31:0]   index_wdata;
    logic [EW-1:0] entry_wdata;

    tlb_op_ctrl #(.TLB_ENTRIES(N), .ENTRY_W(EW)) dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_type(op_type),
        .op_ready(op_ready), .op_done(op_done),
        .cp0_index(cp0_index), .cp0_entry_hi(cp0_entry_hi),
        .cp0_entry(cp0_entry),
        .cp0_wired_we(cp0_wired_we), .cp0_wired_wdata(cp0_wired_wdata),
        .random(random), .tlbrw_index(tlbrw_index),
        .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata),
        .tlbrw_rdata(tlbrw_rdata),
        .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
        .index_we(index_we), .index_wdata(index_wdata),
        .entry_we(entry_we), .entry_wdata(entry_wdata),
        .tlb_flush(tlb_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] probe_fn(input logic [31:0] k);
        return k[8] ? 32'h8000_0000 : {28'h0, k[15:12]};
    endfunction

    // MMU stand-in: one-cycle read and probe latency
    logic [EW-1:0] mmu_mem [N];
    always @(posedge clk) begin
        tlbp_index  <= probe_fn(tlbp_entry_hi);
        tlbrw_rdata <= mmu_mem[tlbrw_index];
        if (tlbrw_we) mmu_mem[tlbrw_index] <= tlbrw_wdata;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: phase counter since accept plus latched operands.
    logic [EW-1:0] ref_mem [N];
    int            ph, ptype, pidx, prnd, rnd, wired;
    logic [31:0]   pkey;
    logic [EW-1:0] pent;

    function automatic int oplen(input int t);
        return (t >= 2) ? (FL ? 2 : 1) : 2;
    endfunction

    task automatic model_reset();
        ph = 0; rnd = N - 1; wired = 0;
    endtask

    task automatic check_outs();
        bit wr;
        int widx;
        wr = (ph != 0) && (ptype >= 2);
        check("ready", op_ready, ph == 0);
        check("done", op_done, ph != 0 && ph == oplen(ptype));
        check("random", random, rnd);
        check("tlbrw_we", tlbrw_we, wr && ph == 1);
        check("index_we", index_we, ph == 2 && ptype == 0);
        check("entry_we", entry_we, ph == 2 && ptype == 1);
        check("flush", tlb_flush, FL && wr && ph == 2);
        if (wr && ph == 1) begin
            widx = (ptype == 3) ? prnd : pidx;
            check("widx", tlbrw_index, widx);
            check("wdata", tlbrw_wdata, pent);
            ref_mem[widx] = pent;
        end
        if (ph == 1 && ptype == 0) check("key", tlbp_entry_hi, pkey);
        if (ph == 1 && ptype == 1) check("ridx", tlbrw_index, pidx);
        if (ph == 2 && ptype == 0) check("pidx", index_wdata, probe_fn(pkey));
        if (ph == 2 && ptype == 1) check("rdata", entry_wdata, ref_mem[pidx]);
    endtask

    task automatic model_upd();
        if (!resetn) begin
            model_reset();
            return;
        end
        if (ph == 0) begin
            if (op_valid) begin
                ptype = int'(op_type);
                pidx  = int'(cp0_index % N);
                pkey  = cp0_entry_hi;
                pent  = cp0_entry;
                prnd  = rnd;
                ph    = 1;
            end
        end else if (ph == oplen(ptype)) begin
            ph = 0;
        end else begin
            ph++;
        end
        if (cp0_wired_we) begin
            wired = int'(cp0_wired_wdata % N);
            rnd   = N - 1;
        end else if (rnd <= wired) begin
            rnd = N - 1;
        end else begin
            rnd--;
        end
    endtask

    task automatic step(input bit v, input logic [1:0] t, input logic [31:0] idx,
                        input logic [31:0] key, input logic [EW-1:0] ent,
                        input bit wwe, input logic [31:0] wdat, input bit rn);
        @(negedge clk);
        check_outs();
        resetn          = rn;
        op_valid        = v;
        op_type         = t;
        cp0_index       = idx;
        cp0_entry_hi    = key;
        cp0_entry       = ent;
        cp0_wired_we    = wwe;
        cp0_wired_wdata = wdat;
        model_upd();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'd0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic op(input logic [1:0] t, input logic [31:0] idx,
                      input logic [31:0] key, input logic [EW-1:0] ent);
        step(1, t, idx, key, ent, 0, 0, 1);
        idle(3);
    endtask

    task automatic wait_rnd(input int val);
        int k;
        k = 0;
        while (rnd != val && k < 40) begin
            idle(1);
            k++;
        end
        check("wait_rnd", k < 40, 1'b1);
    endtask

    initial begin
        logic [EW-1:0] v;
        for (int i = 0; i < N; i++) begin
            v = {$urandom, $urandom};
            mmu_mem[i] = v;
            ref_mem[i] = v;
        end
        resetn = 0; op_valid = 0; op_type = 0; cp0_index = 0;
        cp0_entry_hi = 0; cp0_entry = 0; cp0_wired_we = 0; cp0_wired_wdata = 0;
        ptype = 0; pidx = 0; prnd = 0; pkey = 0; pent = 0;
        model_reset();
        for (int i = 0; i < 2; i++) step(0, 2'd0, 0, 0, 0, 0, 0, 0);
        idle(20);

        wait_rnd(9);
        step(0, 2'd0, 0, 0, 0, 1, 32'hABC0_0004, 1);
        idle(30);

        op(2'd2, 32'h23, 32'h0, 64'hDEAD_BEEF_0123_4567);
        op(2'd0, 0, 32'h0000_0100, 0);
        op(2'd0, 0, 32'h0000_5000, 0);
        op(2'd1, 7, 0, 0);
        op(2'd1, 3, 0, 0);

        wait_rnd(4);
        op(2'd3, 0, 0, 64'h1111_2222_3333_4444);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                 $urandom, $urandom, {$urandom, $urandom},
                 $urandom_range(0, 19) == 0, $urandom, 1);
        end
        idle(4);

        step(1, 2'd2, 5, 0, 64'h5555, 0, 0, 1);
        #1;
        resetn = 0;
        model_reset();
        for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 0, 0, 0, 0, 0);
        idle(10);
        op(2'd1, 5, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
